// File: rtl/cam_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_fifo_if
// Brief    : Bus bundle for cam_fifo: queue handshake plus associative probe.
// Revision : 1.0
// ============================================================================
interface cam_fifo_if #(
    parameter int WIDTH     = 64,
    parameter int KEY_WIDTH = 58,
    parameter int DEPTH     = 8
);
    localparam int LOG_DEPTH = $clog2(DEPTH);

    logic                 flush;
    logic                 push;
    logic [WIDTH-1:0]     data_in;
    logic                 pop;
    logic [WIDTH-1:0]     data_out;
    logic                 empty;
    logic                 full;
    logic [LOG_DEPTH:0]   count;
    logic [KEY_WIDTH-1:0] lookup_key;
    logic                 lookup_hit;
    logic [LOG_DEPTH-1:0] lookup_idx;
    logic [WIDTH-1:0]     lookup_data;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output flush, push, data_in, pop, lookup_key,
        input  data_out, empty, full, count, lookup_hit, lookup_idx,
               lookup_data, overflow, underflow
    );

    modport slave (
        input  flush, push, data_in, pop, lookup_key,
        output data_out, empty, full, count, lookup_hit, lookup_idx,
               lookup_data, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/cam_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cam_fifo
// Brief    : In-order FIFO with a youngest-match associative key lookup.
// Revision : 1.0
// ============================================================================
module cam_fifo #(
    parameter int WIDTH     = 64,
    parameter int KEY_WIDTH = 58,
    parameter int DEPTH     = 8
) (
    input  wire         clk,
    input  wire         reset,
    cam_fifo_if.slave   bus
);
    localparam int LOG_DEPTH = $clog2(DEPTH);
    localparam logic [LOG_DEPTH:0]   C_DEPTH   = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   C_CNT_ONE = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] C_PTR_ONE = LOG_DEPTH'(1);

    logic [WIDTH-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [LOG_DEPTH-1:0] r_head;
    logic [LOG_DEPTH-1:0] r_tail;
    logic [LOG_DEPTH:0]   r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_ok;
    logic                 w_push_ok;
    logic [DEPTH-1:0]     w_match;
    logic                 w_hit;
    logic [LOG_DEPTH-1:0] w_idx;
    logic [LOG_DEPTH-1:0] w_slot;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH);
    assign w_pop_ok  = bus.pop && !w_empty && !bus.flush;
    assign w_push_ok = bus.push && !bus.flush && (!w_full || w_pop_ok);

    // Data storage carries no reset; valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_data[r_tail] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.push && !w_push_ok && !bus.flush;
            r_underflow <= bus.pop  && !w_pop_ok  && !bus.flush;
            if (bus.flush) begin
                r_valid <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // Clear before set so a push+pop at full keeps the shared slot valid.
                if (w_pop_ok) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + C_PTR_ONE;
                end
                if (w_push_ok) begin
                    r_valid[r_tail] <= 1'b1;
                    r_tail          <= r_tail + C_PTR_ONE;
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] &&
                                 (r_data[gi][KEY_WIDTH-1:0] == bus.lookup_key);
        end
    endgenerate

    // Walk slots oldest to youngest from head; the last hit seen is the youngest.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_slot = '0;
        for (int a = 0; a < DEPTH; a++) begin
            w_slot = r_head + LOG_DEPTH'(a);
            if (w_match[w_slot]) begin
                w_hit = 1'b1;
                w_idx = w_slot;
            end
        end
    end

    assign bus.lookup_hit  = w_hit;
    assign bus.lookup_idx  = w_idx;
    assign bus.lookup_data = w_hit ? r_data[w_idx] : '0;
    assign bus.data_out    = r_data[r_head];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_cam_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_fifo
// Brief    : Directed self-checking bench for cam_fifo (DEPTH=8, 64/58 bits).
// Revision : 1.0
// ============================================================================
module tb_cam_fifo;
    localparam int WIDTH     = 64;
    localparam int KEY_WIDTH = 58;
    localparam int DEPTH     = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cam_fifo_if #(.WIDTH(WIDTH), .KEY_WIDTH(KEY_WIDTH), .DEPTH(DEPTH)) bus ();

    cam_fifo #(.WIDTH(WIDTH), .KEY_WIDTH(KEY_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] d);
        bus.push    = 1'b1;
        bus.data_in = d;
        tick();
        bus.push    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.lookup_key = '0;
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b expected 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b expected 0", bus.full); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %b expected 0", bus.lookup_hit); end
        n_cmp++; if (bus.lookup_idx !== 3'd0) begin n_err++; $display("FAIL rst_idx: got %0d expected 0", bus.lookup_idx); end
        n_cmp++; if (bus.lookup_data !== 64'd0) begin n_err++; $display("FAIL rst_ldata: got %h expected 0", bus.lookup_data); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL rst_unf: got %b expected 0", bus.underflow); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 8; i++) push_one(64'h11 + 64'(i));
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fd_full: got %b expected 1", bus.full); end
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL fd_count: got %0d expected 8", bus.count); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.data_out !== 64'h11 + 64'(i)) begin n_err++; $display("FAIL fd_dout%0d: got %h expected %h", i, bus.data_out, 64'h11 + 64'(i)); end
            bus.pop = 1'b1;
            tick();
            bus.pop = 1'b0;
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fd_empty: got %b expected 1", bus.empty); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL fd_count0: got %0d expected 0", bus.count); end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp_seq [8];
        do_reset();
        for (int i = 0; i < 8; i++) push_one(64'h11 + 64'(i));
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 64'h99;
        tick();
        idle();
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL fpp_count: got %0d expected 8", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %b expected 0", bus.overflow); end
        for (int i = 0; i < 7; i++) exp_seq[i] = 64'h12 + 64'(i);
        exp_seq[7] = 64'h99;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.data_out !== exp_seq[i]) begin n_err++; $display("FAIL fpp_dout%0d: got %h expected %h", i, bus.data_out, exp_seq[i]); end
            bus.pop = 1'b1;
            tick();
            bus.pop = 1'b0;
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_wrap_youngest();
        logic [63:0] d1, d2, db, cc1, cc2;
        d1  = 64'h0400_0000_0000_0AAA;
        d2  = 64'h0800_0000_0000_0AAA;
        db  = 64'h0000_0000_0000_0BBB;
        cc1 = 64'h2000_0000_0000_0CCC;
        cc2 = 64'h3000_0000_0000_0CCC;
        do_reset();
        push_one(d1);
        push_one(db);
        push_one(d2);
        bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        // Slots 3..7 then wrap to slot 0; head sits at 1.
        push_one(64'h103);
        push_one(64'h104);
        push_one(64'h105);
        push_one(cc1);
        push_one(64'h107);
        push_one(cc2);
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL wy_count: got %0d expected 8", bus.count); end
        bus.lookup_key = 58'h0AAA; #1;
        n_cmp++; if (bus.lookup_hit !== 1'b1) begin n_err++; $display("FAIL wy_hitA: got %b expected 1", bus.lookup_hit); end
        n_cmp++; if (bus.lookup_data !== d2) begin n_err++; $display("FAIL wy_dataA: got %h expected %h", bus.lookup_data, d2); end
        n_cmp++; if (bus.lookup_idx !== 3'd2) begin n_err++; $display("FAIL wy_idxA: got %0d expected 2", bus.lookup_idx); end
        bus.lookup_key = 58'h0CCC; #1;
        n_cmp++; if (bus.lookup_idx !== 3'd0) begin n_err++; $display("FAIL wy_idxC: got %0d expected 0", bus.lookup_idx); end
        n_cmp++; if (bus.lookup_data !== cc2) begin n_err++; $display("FAIL wy_dataC: got %h expected %h", bus.lookup_data, cc2); end
        bus.lookup_key = 58'h0DDD; #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL wy_hitD: got %b expected 0", bus.lookup_hit); end
        bus.lookup_key = 58'h0AAA;
        bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        n_cmp++; if (bus.lookup_hit !== 1'b1) begin n_err++; $display("FAIL wy_hitA2: got %b expected 1", bus.lookup_hit); end
        bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL wy_hitA3: got %b expected 0", bus.lookup_hit); end
        n_cmp++; if (bus.lookup_idx !== 3'd0) begin n_err++; $display("FAIL wy_idxA3: got %0d expected 0", bus.lookup_idx); end
        n_cmp++; if (bus.lookup_data !== 64'd0) begin n_err++; $display("FAIL wy_dataA3: got %h expected 0", bus.lookup_data); end
    endtask

    task automatic test_errors();
        do_reset();
        for (int i = 0; i < 8; i++) push_one(64'h11 + 64'(i));
        bus.push = 1'b1; bus.data_in = 64'hEE;
        tick();
        idle();
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL er_ovf: got %b expected 1", bus.overflow); end
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL er_count: got %0d expected 8", bus.count); end
        tick();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL er_ovf_clr: got %b expected 0", bus.overflow); end
        n_cmp++; if (bus.data_out !== 64'h11) begin n_err++; $display("FAIL er_head: got %h expected 11", bus.data_out); end
        bus.lookup_key = 58'hEE; #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL er_dropped: got %b expected 0", bus.lookup_hit); end
        for (int i = 0; i < 8; i++) begin bus.pop = 1'b1; tick(); end
        bus.pop = 1'b0;
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL er_unf_pre: got %b expected 0", bus.underflow); end
        bus.pop = 1'b1; tick(); bus.pop = 1'b0;
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL er_unf: got %b expected 1", bus.underflow); end
        tick();
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL er_unf_clr: got %b expected 0", bus.underflow); end
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 64'h55;
        tick();
        idle();
        n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL er_pp_count: got %0d expected 1", bus.count); end
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL er_pp_unf: got %b expected 1", bus.underflow); end
        n_cmp++; if (bus.data_out !== 64'h55) begin n_err++; $display("FAIL er_pp_dout: got %h expected 55", bus.data_out); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        for (int i = 0; i < 5; i++) push_one(64'h21 + 64'(i));
        bus.flush = 1'b1; bus.push = 1'b1; bus.data_in = 64'h77;
        tick();
        idle();
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL fl_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fl_empty: got %b expected 1", bus.empty); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fl_ovf: got %b expected 0", bus.overflow); end
        bus.lookup_key = 58'h23; #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL fl_hit_old: got %b expected 0", bus.lookup_hit); end
        bus.lookup_key = 58'h77; #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL fl_hit_new: got %b expected 0", bus.lookup_hit); end
        for (int i = 0; i < 8; i++) push_one(64'h31 + 64'(i));
        reset = 1'b1; bus.push = 1'b1; bus.data_in = 64'h88;
        tick();
        reset = 1'b0;
        idle();
        bus.lookup_key = 58'h33; #1;
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rs_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_err++; $display("FAIL rs_flags: got empty=%b full=%b expected empty=1 full=0", bus.empty, bus.full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rs_ovf: got %b expected 0", bus.overflow); end
        n_cmp++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 64'd0) begin n_err++; $display("FAIL rs_lookup: got hit=%b data=%h expected hit=0 data=0", bus.lookup_hit, bus.lookup_data); end
    endtask

    task automatic test_lookup_timing();
        do_reset();
        bus.lookup_key = 58'h4242;
        bus.push = 1'b1; bus.data_in = 64'h4242;
        #1;
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL lt_same_push: got %b expected 0", bus.lookup_hit); end
        tick();
        idle();
        n_cmp++; if (bus.lookup_hit !== 1'b1) begin n_err++; $display("FAIL lt_next: got %b expected 1", bus.lookup_hit); end
        n_cmp++; if (bus.lookup_data !== 64'h4242) begin n_err++; $display("FAIL lt_data: got %h expected 4242", bus.lookup_data); end
        bus.pop = 1'b1;
        #1;
        n_cmp++; if (bus.lookup_hit !== 1'b1) begin n_err++; $display("FAIL lt_same_pop: got %b expected 1", bus.lookup_hit); end
        tick();
        idle();
        n_cmp++; if (bus.lookup_hit !== 1'b0) begin n_err++; $display("FAIL lt_after_pop: got %b expected 0", bus.lookup_hit); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL lt_count: got %0d expected 0", bus.count); end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.data_in    = '0;
        bus.lookup_key = '0;
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_wrap_youngest();
        test_errors();
        test_flush_reset();
        test_lookup_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
